uart_tx_param: RTL
==================

# uart_tx_param

Parametrised UART transmitter: the next-generation serial transmit block for the protocols library. It adds configurable data width, baud divisor, parity mode and stop-bit count, plus a valid/ready input handshake that supports back-to-back frames. It sits between a byte/word producer (FIFO or register interface) and the serial `tx` pin. It shifts LSB first at one bit per `CLKS_PER_BIT` clocks.

## Interface
- `DATA_W`, 8: data bits per frame; legal 5..9.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal ≥ 2.
- `PARITY_MODE`, 1: 0 = none, 1 = even, 2 = odd; 3 is illegal (elaboration error).
- `STOP_BITS`, 1: legal 1 or 2.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `din`  in  DATA_W  word to send; sampled only on handshake.
- `din_valid`  in  1  producer has a word.
- `din_ready`  out  1  block can accept a word this cycle.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  high from the cycle after acceptance until the frame ends.
- `frame_done`  out  1  one-cycle pulse on the last clock of the last stop bit.

## Operation
- Reset values:
  - `tx`=1, `busy`=0, `frame_done`=0, `din_ready`=1.
  - State is IDLE and all counters and the shift register are 0.
- Handshake:
  - A word is accepted on any rising edge where `din_valid && din_ready`.
  - On acceptance, `din` is loaded into the shift register and the parity bit is latched: even = ^din, odd = ~^din.
  - Changes to `din` after acceptance have no effect.
- `din_ready` is high in IDLE, and in the final clock of the final stop bit (back-to-back window). It is low in all other cycles.
- FSM states and transitions:
  - IDLE: `tx`=1; goes to START on acceptance.
  - START: `tx`=0 for one bit time, then DATA.
  - DATA: `tx`=shift[0]; shifts right at each bit end. After DATA_W bits it goes to PARITY, or to STOP when PARITY_MODE=0.
  - PARITY: `tx`=latched parity for one bit time, then STOP.
  - STOP: `tx`=1 for STOP_BITS bit times. At the end it goes to START if a word is accepted in that last clock, otherwise to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, cleared on every state change.
  - The bit-end event is count == CLKS_PER_BIT-1.
- Bit counter: width $clog2(DATA_W)+1, with separate counting for data bits and stop bits. It never wraps within a frame.
- Frame length = (1 + DATA_W + (PARITY_MODE!=0) + STOP_BITS) × CLKS_PER_BIT clocks.
- `din_valid` high while `din_ready` is low: the word is not taken and must be held by the producer.
- Reset asserted mid-frame:
  - `tx` goes high immediately (asynchronously) and the frame is abandoned.
  - No `frame_done` pulse is produced.

## Timing
- Acceptance at edge N: `tx` is 0 from edge N+1 for exactly CLKS_PER_BIT clocks.
- Data bit k occupies clocks N+1+(1+k)·CLKS_PER_BIT onward.
- `busy` rises at N+1 and falls on the edge after the last stop-bit clock, unless a new word was accepted in that clock, in which case `busy` stays high.
- Back-to-back frames: the new start bit directly follows the last stop bit with zero idle clocks.
- `frame_done` is registered and aligned with the final stop-bit clock.
- `din_ready` is combinational from state and counters only; it has no path from `din_valid`.

## Structure
- Shared package `uart_pkg`:
  - State enum typedef (IDLE, START, DATA, PARITY, STOP).
  - Parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD, shared with the planned receiver.
- One sub-module, `uart_baud_gen`:
  - Parameter CLKS_PER_BIT.
  - Inputs `clk`, `rst`, `clear`; output `bit_end` pulse.
  - Reused by the receiver.
- Top holds the FSM, shift register, bit counter and handshake logic.

## Test plan
- DATA_W=8, CPB=4, even parity, 1 stop; send 0xA5:
  - `tx` sequence per 4 clocks is 0,1,0,1,0,0,1,0,1,0(parity),1.
  - `frame_done` pulses at clock 44 after acceptance.
- Odd parity, send 0x00: parity bit 1. Even parity, send 0xFF: parity bit 0.
- PARITY_MODE=0, STOP_BITS=2, DATA_W=7; send 0x55: frame is 10 bits = 40 clocks, with two high stop bits and no parity bit.
- Hold `din_valid` high with 0x12 then 0x34:
  - Second start bit begins the clock after the first frame's last stop clock.
  - `busy` never drops.
  - `din_ready` high only in that single clock.
- Change `din` mid-frame to 0xFF after accepting 0x0F: transmitted bits still match 0x0F.
- Assert `rst` low during DATA bit 3:
  - `tx`=1 asynchronously; `busy`=0, `din_ready`=1, no `frame_done`.
  - After release, a new frame for 0x3C transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and parity helper,
// common to the transmitter and the planned receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Words narrower than 9 bits are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_of(logic [1:0] mode, logic [8:0] data);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit.
// bit_end_next flags the clock before, so callers can register bit-aligned pulses.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end,
  output logic bit_end_next
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  assign bit_end      = (cnt == LAST);
  assign bit_end_next = (cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (clear || bit_end) cnt <= '0;
    else                       cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready word input, LSB-first serial output
// with optional parity and 1 or 2 stop bits; back-to-back frames without idle gap.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_param: DATA_W must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic [1:0]    PMODE     = 2'(PARITY_MODE);
  localparam bit            HAS_PAR   = (PMODE != PAR_NONE);

  uart_state_e       state;
  logic [DATA_W-1:0] shift;
  logic [BW-1:0]     bit_cnt;
  logic              par_bit;
  logic              bit_end, bit_end_next;
  logic              last_stop, accept;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk          (clk),
    .rst          (rst),
    .clear        (state == IDLE),
    .bit_end      (bit_end),
    .bit_end_next (bit_end_next)
  );

  // The final stop clock doubles as the acceptance window for the next word.
  assign last_stop = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
  assign din_ready = (state == IDLE) || last_stop;
  assign accept    = din_valid && din_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == STOP) && bit_end_next && (bit_cnt == STOP_LAST);
      if (accept) begin
        shift   <= din;
        par_bit <= parity_of(PMODE, 9'(din));
        bit_cnt <= '0;
        state   <= START;
        tx      <= 1'b0;
        busy    <= 1'b1;
      end else begin
        unique case (state)
          IDLE: ;
          START: if (bit_end) begin
            state <= DATA;
            tx    <= shift[0];
          end
          DATA: if (bit_end) begin
            shift <= shift >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= HAS_PAR ? PARITY : STOP;
              tx      <= HAS_PAR ? par_bit : 1'b1;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              tx      <= shift[1];
            end
          end
          PARITY: if (bit_end) begin
            state   <= STOP;
            bit_cnt <= '0;
            tx      <= 1'b1;
          end
          STOP: if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              state   <= IDLE;
              bit_cnt <= '0;
              busy    <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
